// File: rtl/clk_reset_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clk_reset_pkg
//  Description : Shared types and widths for the clock/reset sequencer:
//                the lock-qualification FSM state encoding and the widths
//                of the qualification counter, clock-enable divider, enable
//                phase counter and lock-loss counter.
//  Revision    : 1.0  initial release
// ============================================================================
package clk_reset_pkg;

  // Sequencer states. Explicit 2-bit encoding keeps the state register width
  // fixed regardless of tool enum sizing.
  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_STABLE    = 2'd1,
    ST_HOLD      = 2'd2,
    ST_RUN       = 2'd3
  } state_e;

  // Qualification / hold counter width (covers LOCK_STABLE and RESET_HOLD
  // up to 65535).
  localparam int c_cnt_w   = 16;
  // Divider width for the cen_28m generator (CEN_DIV up to 15).
  localparam int c_div_w   = 4;
  // Position of cen_28m within one cen_7m period (four cen_28m pulses).
  localparam int c_phase_w = 2;
  // Saturating lock-loss counter width.
  localparam int c_lost_w  = 8;

endpackage : clk_reset_pkg
`default_nettype wire

// File: rtl/clk_reset_seq_sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchronizer bringing an asynchronous level into
//                the clk domain. Output lags the input by two clk edges.
//  Ports       : clk    in  1  destination clock (rising edge)
//                reset  in  1  synchronous active-high reset, clears both flops
//                d      in  1  asynchronous input level
//                q      out 1  synchronized level (second flop)
//  Revision    : 1.0  initial release
// ============================================================================
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic meta_d;
  logic sync_q;
  logic sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/clk_reset_seq.sv
`default_nettype none
// ============================================================================
//  Module      : clk_reset_seq
//  Description : Power-up clock/reset sequencer. Qualifies the PLL lock
//                indicator (LOCK_STABLE cycles of continuous lock), then
//                holds the downstream reset for RESET_HOLD more cycles before
//                entering RUN. In RUN it generates a CEN_DIV-cycle clock
//                enable (cen_28m) and two quarter-rate enables on opposite
//                phases (cen_7m, cen_7m_n). Any loss of lock drops straight
//                back to WAIT_LOCK and is counted (saturating).
//  Ports       : clk            in  1  PLL output clock, rising edge
//                reset          in  1  synchronous active-high reset
//                pll_lock       in  1  raw asynchronous PLL lock indicator
//                sys_reset      out 1  registered active-high downstream reset
//                ready          out 1  high while in RUN
//                cen_28m        out 1  enable pulse every CEN_DIV cycles in RUN
//                cen_7m         out 1  every 4th cen_28m (rising phase)
//                cen_7m_n       out 1  cen_28m two pulses after cen_7m
//                lock_lost_cnt  out 8  saturating count of lock losses
//  Revision    : 1.0  initial release
// ============================================================================
module clk_reset_seq
  import clk_reset_pkg::*;
#(
  parameter int LOCK_STABLE = 1024,
  parameter int RESET_HOLD  = 256,
  parameter int CEN_DIV     = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pll_lock,
  output logic                sys_reset,
  output logic                ready,
  output logic                cen_28m,
  output logic                cen_7m,
  output logic                cen_7m_n,
  output logic [c_lost_w-1:0] lock_lost_cnt
);

  // Terminal counts, sized to the registers they are compared against.
  localparam logic [c_cnt_w-1:0]   c_stable_last = c_cnt_w'(LOCK_STABLE - 1);
  localparam logic [c_cnt_w-1:0]   c_hold_last   = c_cnt_w'(RESET_HOLD - 1);
  localparam logic [c_div_w-1:0]   c_div_last    = c_div_w'(CEN_DIV - 1);
  localparam logic [c_cnt_w-1:0]   c_cnt_one     = c_cnt_w'(1);
  localparam logic [c_div_w-1:0]   c_div_one     = c_div_w'(1);
  localparam logic [c_phase_w-1:0] c_phase_one   = c_phase_w'(1);
  localparam logic [c_phase_w-1:0] c_phase_rise  = c_phase_w'(3);
  localparam logic [c_phase_w-1:0] c_phase_fall  = c_phase_w'(1);
  localparam logic [c_lost_w-1:0]  c_lost_one    = c_lost_w'(1);
  localparam logic [c_lost_w-1:0]  c_lost_max    = '1;

  // --------------------------------------------------------------------------
  // Lock synchronizer
  // --------------------------------------------------------------------------
  logic lock_s;

  sync_2ff u_sync_lock (
    .clk   (clk),
    .reset (reset),
    .d     (pll_lock),
    .q     (lock_s)
  );

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e               state_q;
  state_e               state_d;
  logic [c_cnt_w-1:0]   cnt_q;
  logic [c_cnt_w-1:0]   cnt_d;
  logic [c_div_w-1:0]   div_cnt_q;
  logic [c_div_w-1:0]   div_cnt_d;
  logic [c_phase_w-1:0] phase_q;
  logic [c_phase_w-1:0] phase_d;
  logic [c_lost_w-1:0]  lost_q;
  logic [c_lost_w-1:0]  lost_d;
  logic                 sys_reset_q;
  logic                 sys_reset_d;

  logic                 w_lock_loss;
  logic                 w_in_run;
  logic                 w_stay_run;
  logic                 w_cen_28m;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_WAIT_LOCK;
      cnt_q       <= '0;
      div_cnt_q   <= '0;
      phase_q     <= '0;
      lost_q      <= '0;
      sys_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_cnt_q   <= div_cnt_d;
      phase_q     <= phase_d;
      lost_q      <= lost_d;
      sys_reset_q <= sys_reset_d;
    end
  end

  // --------------------------------------------------------------------------
  // Lock-qualification FSM
  // --------------------------------------------------------------------------
  // The counter is cleared whenever it is not actively counting, so a lock
  // glitch always restarts qualification from zero.
  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    w_lock_loss = 1'b0;

    if ((state_q != ST_WAIT_LOCK) && !lock_s) begin
      // Lock loss overrides every other transition.
      state_d     = ST_WAIT_LOCK;
      w_lock_loss = 1'b1;
    end else begin
      unique case (state_q)
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = ST_STABLE;
          end
        end
        ST_STABLE: begin
          if (cnt_q == c_stable_last) begin
            state_d = ST_HOLD;
          end else begin
            cnt_d = cnt_q + c_cnt_one;
          end
        end
        ST_HOLD: begin
          if (cnt_q == c_hold_last) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q + c_cnt_one;
          end
        end
        ST_RUN: begin
          state_d = ST_RUN;
        end
        default: begin
          state_d = ST_WAIT_LOCK;
        end
      endcase
    end
  end

  // sys_reset looks at the next state so it releases on the very edge that
  // enters RUN, rather than one cycle later.
  always_comb begin
    sys_reset_d = (state_d != ST_RUN);
  end

  always_comb begin
    lost_d = lost_q;
    if (w_lock_loss && (lost_q != c_lost_max)) begin
      lost_d = lost_q + c_lost_one;
    end
  end

  // --------------------------------------------------------------------------
  // Clock-enable generation
  // --------------------------------------------------------------------------
  // Divider and phase only advance while RUN continues into the next cycle;
  // entering or leaving RUN leaves them at zero, so the first RUN cycle
  // always starts at div_cnt == 0, phase == 0.
  always_comb begin
    w_in_run   = (state_q == ST_RUN);
    w_stay_run = w_in_run && (state_d == ST_RUN);
    w_cen_28m  = w_in_run && (div_cnt_q == c_div_last);

    div_cnt_d = '0;
    phase_d   = '0;
    if (w_stay_run) begin
      if (div_cnt_q == c_div_last) begin
        div_cnt_d = '0;
      end else begin
        div_cnt_d = div_cnt_q + c_div_one;
      end

      // Phase counts cen_28m pulses modulo 4 (natural 2-bit wrap).
      if (w_cen_28m) begin
        phase_d = phase_q + c_phase_one;
      end else begin
        phase_d = phase_q;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign sys_reset     = sys_reset_q;
  assign ready         = w_in_run;
  assign cen_28m       = w_cen_28m;
  // Phases 3 and 1 are half a cen_7m period apart, so these never coincide.
  assign cen_7m        = w_cen_28m && (phase_q == c_phase_rise);
  assign cen_7m_n      = w_cen_28m && (phase_q == c_phase_fall);
  assign lock_lost_cnt = lost_q;

endmodule : clk_reset_seq
`default_nettype wire

// File: tb/tb_clk_reset_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_reset_seq
//  Description : Self-checking bench for clk_reset_seq with LOCK_STABLE=8,
//                RESET_HOLD=4, CEN_DIV=5. Expected output snapshots are
//                queued as stimulus is applied and compared as each edge
//                completes.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_clk_reset_seq;

  localparam int LOCK_STABLE = 8;
  localparam int RESET_HOLD  = 4;
  localparam int CEN_DIV     = 5;
  // Edges from first sampled lock to RUN: 2 synchronizer + stable + hold.
  localparam int RUN_EDGE    = 2 + LOCK_STABLE + RESET_HOLD;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_lock;
  logic       sys_reset;
  logic       ready;
  logic       cen_28m;
  logic       cen_7m;
  logic       cen_7m_n;
  logic [7:0] lock_lost_cnt;

  clk_reset_seq #(
    .LOCK_STABLE (LOCK_STABLE),
    .RESET_HOLD  (RESET_HOLD),
    .CEN_DIV     (CEN_DIV)
  ) u_dut (
    .clk           (clk),
    .reset         (reset),
    .pll_lock      (pll_lock),
    .sys_reset     (sys_reset),
    .ready         (ready),
    .cen_28m       (cen_28m),
    .cen_7m        (cen_7m),
    .cen_7m_n      (cen_7m_n),
    .lock_lost_cnt (lock_lost_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       sys_reset;
    logic       ready;
    logic       c28;
    logic       c7;
    logic       c7n;
    logic [7:0] lost;
    logic       chk_cen;
  } snap_t;

  snap_t sb[$];
  int    checks = 0;
  int    errors = 0;

  function automatic snap_t mk(logic sr, logic rdy, logic c28, logic c7,
                               logic c7n, int lost, logic chk);
    snap_t s;
    s.sys_reset = sr;
    s.ready     = rdy;
    s.c28       = c28;
    s.c7        = c7;
    s.c7n       = c7n;
    s.lost      = 8'(lost);
    s.chk_cen   = chk;
    return s;
  endfunction

  function automatic snap_t observe();
    return mk(sys_reset, ready, cen_28m, cen_7m, cen_7m_n, int'(lock_lost_cnt), 1'b1);
  endfunction

  function automatic string show(snap_t s);
    return $sformatf("sr=%b rdy=%b cen28/7/7n=%b%b%b lost=%0d",
                     s.sys_reset, s.ready, s.c28, s.c7, s.c7n, s.lost);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    reset    = 1'b1;
    pll_lock = 1'b0;
    repeat (3) tick();
    checks++;
    if (sys_reset !== 1'b1) begin
      errors++; $display("FAIL reset_sys_reset: got %b want 1", sys_reset);
    end
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b want 0", ready);
    end
    checks++;
    if ({cen_28m, cen_7m, cen_7m_n} !== 3'b000) begin
      errors++; $display("FAIL reset_cens: got %b%b%b want 000", cen_28m, cen_7m, cen_7m_n);
    end
    checks++;
    if (lock_lost_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_lost_cnt: got %0d want 0", lock_lost_cnt);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_bringup();
    snap_t e, o;
    reset    = 1'b0;
    pll_lock = 1'b1;
    for (int n = 0; n <= RUN_EDGE; n++) begin
      sb.push_back(mk(n < RUN_EDGE, n >= RUN_EDGE, 1'b0, 1'b0, 1'b0, 0, 1'b1));
      tick();
      e = sb.pop_front();
      o = observe();
      checks++;
      if (o.sys_reset !== e.sys_reset || o.ready !== e.ready || o.lost !== e.lost ||
          (e.chk_cen && {o.c28, o.c7, o.c7n} !== {e.c28, e.c7, e.c7n})) begin
        errors++;
        $display("FAIL bringup_e%0d: got %s, want %s", n, show(o), show(e));
      end
    end
  endtask

  // --------------------------------------------------------------------------
  // Continues from RUN cycle 0 left by test_bringup.
  task automatic test_cen_phases();
    snap_t e, o;
    logic  c28;
    int    k;
    for (int c = 1; c < 60; c++) begin
      c28 = ((c % CEN_DIV) == CEN_DIV - 1);
      k   = c / CEN_DIV;
      sb.push_back(mk(1'b0, 1'b1, c28, c28 && (k % 4 == 3), c28 && (k % 4 == 1), 0, 1'b1));
      tick();
      e = sb.pop_front();
      o = observe();
      checks++;
      if (o.sys_reset !== e.sys_reset || o.ready !== e.ready || o.lost !== e.lost ||
          (e.chk_cen && {o.c28, o.c7, o.c7n} !== {e.c28, e.c7, e.c7n})) begin
        errors++;
        $display("FAIL cen_run_cycle%0d: got %s, want %s", c, show(o), show(e));
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_stable_glitch();
    snap_t e, o;
    reset    = 1'b1;
    pll_lock = 1'b0;
    tick();
    reset    = 1'b0;
    pll_lock = 1'b1;
    // e0..e4 with lock high; STABLE from e2.
    for (int n = 0; n <= 5; n++) begin
      if (n == 5) pll_lock = 1'b0;   // single-cycle dropout sampled at e5
      sb.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1));
      tick();
      e = sb.pop_front();
      o = observe();
      checks++;
      if (o.sys_reset !== e.sys_reset || o.ready !== e.ready || o.lost !== e.lost ||
          (e.chk_cen && {o.c28, o.c7, o.c7n} !== {e.c28, e.c7, e.c7n})) begin
        errors++;
        $display("FAIL glitch_pre_e%0d: got %s, want %s", n, show(o), show(e));
      end
    end
    pll_lock = 1'b1;
    // New e0 is the edge after the dropout; loss is seen one edge later.
    for (int n = 0; n <= RUN_EDGE; n++) begin
      sb.push_back(mk(n < RUN_EDGE, n >= RUN_EDGE, 1'b0, 1'b0, 1'b0,
                      (n >= 1) ? 1 : 0, 1'b1));
      tick();
      e = sb.pop_front();
      o = observe();
      checks++;
      if (o.sys_reset !== e.sys_reset || o.ready !== e.ready || o.lost !== e.lost ||
          (e.chk_cen && {o.c28, o.c7, o.c7n} !== {e.c28, e.c7, e.c7n})) begin
        errors++;
        $display("FAIL glitch_relock_e%0d: got %s, want %s", n, show(o), show(e));
      end
    end
  endtask

  // --------------------------------------------------------------------------
  // Continues from RUN (lock_lost_cnt == 1) left by test_stable_glitch.
  task automatic test_run_loss();
    snap_t e, o;
    for (int n = 0; n < 11; n++) begin
      if (n == 7) pll_lock = 1'b0;
      // Two edges of synchronizer latency still show RUN; cens are not
      // predicted there. From the third edge on, reset and quiet cens.
      if (n < 9) sb.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0));
      else       sb.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b1));
      tick();
      e = sb.pop_front();
      o = observe();
      checks++;
      if (o.sys_reset !== e.sys_reset || o.ready !== e.ready || o.lost !== e.lost ||
          (e.chk_cen && {o.c28, o.c7, o.c7n} !== {e.c28, e.c7, e.c7n})) begin
        errors++;
        $display("FAIL run_loss_step%0d: got %s, want %s", n, show(o), show(e));
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_lost_saturate();
    snap_t e, o;
    reset    = 1'b1;
    pll_lock = 1'b0;
    tick();
    reset    = 1'b0;
    for (int i = 0; i < 256; i++) begin
      pll_lock = 1'b1;
      repeat (3) tick();           // reaches STABLE on the third edge
      pll_lock = 1'b0;
      sb.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, (i + 1 > 255) ? 255 : i + 1, 1'b1));
      repeat (3) tick();           // loss lands on the third edge
      e = sb.pop_front();
      o = observe();
      checks++;
      if (o.sys_reset !== e.sys_reset || o.ready !== e.ready || o.lost !== e.lost ||
          (e.chk_cen && {o.c28, o.c7, o.c7n} !== {e.c28, e.c7, e.c7n})) begin
        errors++;
        $display("FAIL lost_event%0d: got %s, want %s", i, show(o), show(e));
      end
    end
  endtask

  // --------------------------------------------------------------------------
  // Continues with lock_lost_cnt saturated at 255.
  task automatic test_reset_mid_run();
    snap_t e, o;
    pll_lock = 1'b1;
    sb.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 255, 1'b0));
    repeat (RUN_EDGE + 6) tick();
    e = sb.pop_front();
    o = observe();
    checks++;
    if (o.sys_reset !== e.sys_reset || o.ready !== e.ready || o.lost !== e.lost) begin
      errors++;
      $display("FAIL midrun_pre: got %s, want %s", show(o), show(e));
    end
    reset = 1'b1;
    sb.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1));
    tick();
    e = sb.pop_front();
    o = observe();
    checks++;
    if (o.sys_reset !== e.sys_reset || o.ready !== e.ready || o.lost !== e.lost ||
        (e.chk_cen && {o.c28, o.c7, o.c7n} !== {e.c28, e.c7, e.c7n})) begin
      errors++;
      $display("FAIL midrun_reset: got %s, want %s", show(o), show(e));
    end
    reset = 1'b0;
    // Synchronizer was cleared, so qualification restarts from scratch.
    for (int n = 0; n <= RUN_EDGE; n++) begin
      sb.push_back(mk(n < RUN_EDGE, n >= RUN_EDGE, 1'b0, 1'b0, 1'b0, 0, 1'b1));
      tick();
      e = sb.pop_front();
      o = observe();
      checks++;
      if (o.sys_reset !== e.sys_reset || o.ready !== e.ready || o.lost !== e.lost ||
          (e.chk_cen && {o.c28, o.c7, o.c7n} !== {e.c28, e.c7, e.c7n})) begin
        errors++;
        $display("FAIL midrun_requal_e%0d: got %s, want %s", n, show(o), show(e));
      end
    end
  endtask

  // --------------------------------------------------------------------------
  initial begin
    test_reset();
    test_bringup();
    test_cen_phases();
    test_stable_glitch();
    test_run_loss();
    test_lost_saturate();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule : tb_clk_reset_seq
`default_nettype wire
